// File: rtl/cam_pixel_capture_pkg.sv
// Shared types and constants for the camera pixel capture path.
package cam_pixel_capture_pkg;

    localparam int LINE_PIXELS_DEF = 640;
    localparam int FRAME_LINES_DEF = 480;

    // RGB565 field positions within the assembled pixel
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        IN_VSYNC   = 2'd1,
        WAIT_LINE  = 2'd2,
        CAPTURE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/cam_byte_pairer.sv
// Tracks even/odd byte phase and assembles two camera bytes into one RGB565 pixel.
module cam_byte_pairer
    import cam_pixel_capture_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        pair_done,
    output logic        odd_pending,
    output logic        pix_valid,
    output logic [15:0] pix_data
);

    logic        odd_q, odd_d;
    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        odd_d     = odd_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        pair_done = 1'b0;
        if (clear) begin
            odd_d = 1'b0;
        end else if (byte_en) begin
            if (!odd_q) begin
                data_d[RGB_R_MSB:RGB_R_LSB]   = byte_in[7:3];
                data_d[RGB_G_MSB:RGB_G_MSB-2] = byte_in[2:0];
                odd_d = 1'b1;
            end else begin
                data_d[RGB_G_LSB+2:RGB_G_LSB] = byte_in[7:5];
                data_d[RGB_B_MSB:RGB_B_LSB]   = byte_in[4:0];
                valid_d   = 1'b1;
                odd_d     = 1'b0;
                pair_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            odd_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            odd_q   <= odd_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign odd_pending = odd_q;
    assign pix_valid   = valid_q;
    assign pix_data    = data_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera line capture: frame/line sequencing and ping-pong line buffer control.
// state      | meaning
// WAIT_VSYNC | idle until a frame sync; lines are ignored
// IN_VSYNC   | frame sync high; next low edge opens the frame
// WAIT_LINE  | frame open, waiting for HREF
// CAPTURE    | bytes of one line being accepted
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int FRAME_LINES = FRAME_LINES_DEF
) (
    input  logic        camPCLK,
    input  logic        reset,
    input  logic        camVSYNC,
    input  logic        HREF,
    input  logic [7:0]  pixData,
    output logic [15:0] pixOutput,
    output logic        pixValid,
    output logic [9:0]  pixAddr,
    output logic        writeBuff1,
    output logic        writeBuff2,
    output logic        buffClear1,
    output logic        buffClear2,
    output logic        lineReady,
    output logic        lineBuff,
    output logic [8:0]  lineCount,
    output logic        frameDone,
    output logic        lineError
);

    localparam logic [10:0] LINE_PIX_N    = 11'(LINE_PIXELS);
    localparam logic [8:0]  FRAME_LINES_N = 9'(FRAME_LINES);

    cap_state_e  state_q, state_d;
    logic        sel_q, sel_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [9:0]  pix_addr_q, pix_addr_d;
    logic [8:0]  line_cnt_q, line_cnt_d;
    logic        ready_q, ready_d;
    logic        line_buff_q, line_buff_d;
    logic        done_q, done_d;
    logic        clr1_q, clr1_d;
    logic        clr2_q, clr2_d;
    logic        err_q, err_d;
    logic        vsync_q, vsync_d;

    logic        vsync_rise, line_active, overflow, byte_en, line_end, commit;
    logic        pair_done, odd_pending, pix_valid;
    logic [15:0] pix_data;

    assign vsync_rise  = camVSYNC & ~vsync_q;
    assign line_active = (state_q == WAIT_LINE) || (state_q == CAPTURE);
    assign overflow    = (pix_cnt_q == LINE_PIX_N);
    assign byte_en     = !camVSYNC && HREF && line_active && !overflow;
    assign line_end    = !camVSYNC && !HREF && (state_q == CAPTURE);
    // extra bytes past a full line are dropped, so a full line still ends on an even phase
    assign commit      = line_end && overflow && !odd_pending;

    cam_byte_pairer u_pairer (
        .clk        (camPCLK),
        .reset      (reset),
        .clear      (camVSYNC | line_end),
        .byte_en    (byte_en),
        .byte_in    (pixData),
        .pair_done  (pair_done),
        .odd_pending(odd_pending),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        line_cnt_d  = line_cnt_q;
        line_buff_d = line_buff_q;
        pix_addr_d  = pix_addr_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        clr1_d      = 1'b0;
        clr2_d      = 1'b0;
        err_d       = err_q;
        vsync_d     = camVSYNC;
        pix_cnt_d   = '0;

        if (state_q == CAPTURE && !camVSYNC && HREF) begin
            pix_cnt_d = pix_cnt_q + {10'd0, pair_done};
        end
        if (pair_done) begin
            pix_addr_d = pix_cnt_q[9:0];
        end

        if (vsync_rise)                                       err_d = 1'b0;
        if (camVSYNC && state_q == CAPTURE)                   err_d = 1'b1;
        if (!camVSYNC && HREF && state_q == CAPTURE && overflow) err_d = 1'b1;
        if (line_end && !commit)                              err_d = 1'b1;

        if (camVSYNC) begin
            state_d = IN_VSYNC;
        end else begin
            case (state_q)
                WAIT_VSYNC: ;
                IN_VSYNC: begin
                    state_d    = WAIT_LINE;
                    line_cnt_d = '0;
                    clr1_d     = !sel_q;
                    clr2_d     = sel_q;
                end
                WAIT_LINE: begin
                    if (HREF) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (!HREF) begin
                        state_d = WAIT_LINE;
                        if (commit) begin
                            ready_d     = 1'b1;
                            line_buff_d = sel_q;
                            sel_d       = !sel_q;
                            clr1_d      = sel_q;
                            clr2_d      = !sel_q;
                            line_cnt_d  = line_cnt_q + 9'd1;
                            if (line_cnt_q + 9'd1 == FRAME_LINES_N) begin
                                done_d  = 1'b1;
                                state_d = WAIT_VSYNC;
                            end
                        end
                    end
                end
                default: state_d = WAIT_VSYNC;
            endcase
        end
    end

    always_ff @(posedge camPCLK) begin
        if (reset) begin
            state_q     <= WAIT_VSYNC;
            sel_q       <= 1'b0;
            pix_cnt_q   <= '0;
            pix_addr_q  <= '0;
            line_cnt_q  <= '0;
            ready_q     <= 1'b0;
            line_buff_q <= 1'b0;
            done_q      <= 1'b0;
            clr1_q      <= 1'b0;
            clr2_q      <= 1'b0;
            err_q       <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_addr_q  <= pix_addr_d;
            line_cnt_q  <= line_cnt_d;
            ready_q     <= ready_d;
            line_buff_q <= line_buff_d;
            done_q      <= done_d;
            clr1_q      <= clr1_d;
            clr2_q      <= clr2_d;
            err_q       <= err_d;
            vsync_q     <= vsync_d;
        end
    end

    assign pixOutput  = pix_data;
    assign pixValid   = pix_valid;
    assign pixAddr    = pix_addr_q;
    assign writeBuff1 = pix_valid & ~sel_q;
    assign writeBuff2 = pix_valid & sel_q;
    assign buffClear1 = clr1_q;
    assign buffClear2 = clr2_q;
    assign lineReady  = ready_q;
    assign lineBuff   = line_buff_q;
    assign lineCount  = line_cnt_q;
    assign frameDone  = done_q;
    assign lineError  = err_q;

endmodule
